riscv_mc_control: RTL

Multi-cycle control FSM for the RV32I merge-sort core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: ALU, immediate decoder, register file, PC and the single unified memory port. It arbitrates that memory port between instruction fetch and load/store, and drives every datapath select and write strobe. It also halts the core on ECALL/EBREAK, which marks sort completion.

---
 rtl/riscv_ctrl_pkg.sv | 41 ++++
 rtl/riscv_branch_cond.sv | 27 ++
 rtl/riscv_mc_control.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encoding,
// major opcodes and the datapath select encodings driven by the controller.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;  // old_pc + 4
    localparam logic [1:0] PC_SRC_REL    = 2'b01;  // old_pc + imm
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;  // ALU & ~1

    localparam logic [1:0] ALU_A_RS1     = 2'b00;
    localparam logic [1:0] ALU_A_OLD_PC  = 2'b01;
    localparam logic [1:0] ALU_A_ZERO    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU    = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_PC4    = 2'b10;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_OP_CMP    = 2'b10;

endpackage

// File: rtl/riscv_branch_cond.sv
// Branch resolution: maps funct3 and the ALU compare flags (rs1 vs rs2) to
// a taken/not-taken decision. funct3 010/011 are not branches and never taken.
module riscv_branch_cond (
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_taken
);

    // Decode funct3 into the selected flag or its complement
    always_comb begin
        // NOTE: o_taken gets a default before the case so no path leaves it
        // unassigned; without it the synthesiser would infer a latch.
        o_taken = 1'b0;
        case (i_funct3)
            3'b000:  o_taken = i_zero;
            3'b001:  o_taken = !i_zero;
            3'b100:  o_taken = i_lt;
            3'b101:  o_taken = !i_lt;
            3'b110:  o_taken = i_ltu;
            3'b111:  o_taken = !i_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle control FSM for the RV32I merge-sort core. Sequences
// FETCH/DECODE/EXEC/MEM/WB, arbitrates the unified memory port, guards
// memory requests with a wait-cycle timeout and counts retired instructions.
// Build option: define RISCV_CTRL_ILLEGAL_TRAP_EN to halt on unlisted opcodes
// (sets illegal); otherwise they execute as NOPs and illegal reads 0.
module riscv_mc_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic        mem_err,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    // Value of the wait counter on the last tolerated stalled cycle.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      r_state;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [7:0]  r_wait;
    logic        r_halt;
    logic        r_mem_err;
    logic [31:0] r_instret;

    state_e      w_next;
    logic        w_taken;
    logic        w_timeout;
    logic        w_retire;
    logic        w_set_halt;
    logic        w_set_err;
    logic        w_is_jump;

    riscv_branch_cond u_branch_cond (
        .i_funct3 (r_funct3),
        .i_zero   (alu_zero),
        .i_lt     (alu_lt),
        .i_ltu    (alu_ltu),
        .o_taken  (w_taken)
    );

    // A stalled request times out on its MEM_TIMEOUT-th cycle without mem_ready
    assign w_timeout = (r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready
                       && (r_wait == LP_WAIT_LAST);
    assign w_is_jump = (r_opcode == OPC_JAL) || (r_opcode == OPC_JALR);

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_set_illegal;
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Next-state and datapath control decode from state and latched opcode
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_set_halt   = 1'b0;
        w_set_err    = 1'b0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = 1'b0;
        alu_op       = ALU_OP_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_timeout) begin
                    w_set_err  = 1'b1;
                    w_set_halt = 1'b1;
                    w_next     = ST_HALT;
                end
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                case (r_opcode)
                    OPC_OP: begin
                        alu_op = ALU_OP_FUNCT;
                        w_next = ST_WB;
                    end
                    OPC_OP_IMM: begin
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_OP_FUNCT;
                        w_next    = ST_WB;
                    end
                    OPC_LUI: begin
                        alu_a_sel = ALU_A_ZERO;
                        alu_b_sel = 1'b1;
                        w_next    = ST_WB;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = ALU_A_OLD_PC;
                        alu_b_sel = 1'b1;
                        w_next    = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 1'b1;
                        w_next    = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_op   = ALU_OP_CMP;
                        pc_write = 1'b1;
                        pc_src   = w_taken ? PC_SRC_REL : PC_SRC_PLUS4;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                    OPC_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_REL;
                        w_next   = ST_WB;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_ALU;
                        w_next    = ST_WB;
                    end
                    OPC_SYSTEM: begin
                        w_set_halt = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = ST_HALT;
                    end
                    default: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                        w_set_illegal = 1'b1;
                        w_set_halt    = 1'b1;
                        w_next        = ST_HALT;
`else
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_opcode == OPC_STORE);
                if (mem_ready) begin
                    if (r_opcode == OPC_STORE) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_set_err  = 1'b1;
                    w_set_halt = 1'b1;
                    w_next     = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (r_opcode == OPC_LOAD) wb_sel = WB_SEL_MEM;
                else if (w_is_jump)       wb_sel = WB_SEL_PC4;
                pc_write = !w_is_jump;
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end
            default: w_next = ST_HALT;
        endcase
        // Reset abandons the current instruction: no strobe may reach the datapath
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // State, opcode latch, wait counter, sticky status and retire counter
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so all of them
        // sample the pre-edge values; blocking would create order-dependent logic.
        if (reset) begin
            r_state   <= ST_FETCH;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_wait    <= '0;
            r_halt    <= 1'b0;
            r_mem_err <= 1'b0;
            r_instret <= '0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= opcode;
                r_funct3 <= funct3;
            end
            if ((r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready && !w_timeout)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= '0;
            if (w_retire)   r_instret <= r_instret + 32'd1;
            if (w_set_halt) r_halt    <= 1'b1;
            if (w_set_err)  r_mem_err <= 1'b1;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            if (w_set_illegal) r_illegal <= 1'b1;
`endif
        end
    end

    assign halt    = r_halt;
    assign mem_err = r_mem_err;
    assign instret = r_instret;
    assign state   = r_state;

endmodule
